// File: rtl/bus_pkg.sv
// Shared definitions for the serial address bus: state encoding, mode-bit
// values and default field widths so master and decoder agree.
package bus_pkg;

  localparam int DEF_DEVICE_ADDR_WIDTH = 4;
  localparam int DEF_MEM_ADDR_WIDTH    = 12;
  localparam int DEF_DATA_WIDTH        = 8;
  localparam int DEF_ACK_TIMEOUT       = 15;

  localparam logic MODE_WRITE = 1'b1;
  localparam logic MODE_READ  = 1'b0;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ARB,
    ST_DEV_ADDR,
    ST_WAIT_ACK,
    ST_MODE,
    ST_MEM_ADDR,
    ST_WDATA,
    ST_WR_WAIT,
    ST_RD,
    ST_SPLIT_WAIT
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/serial_shifter.sv
// LSB-first shift register with bit counter: parallel load then serial out
// on sout, or serial in at the MSB end so the first bit lands in bit 0.
module serial_shifter #(
  parameter int W  = 8,
  parameter int CW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          load,
  input  logic [W-1:0]  load_data,
  input  logic [CW-1:0] len,
  input  logic          shift,
  input  logic          sin,
  output logic          sout,
  output logic [W-1:0]  shifted,
  output logic [CW-1:0] cnt,
  output logic          last
);

  logic [W-1:0] sr;

  // load wins over shift so a phase change can reload on its final bit
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sr  <= '0;
      cnt <= '0;
    end else if (load) begin
      sr  <= load_data;
      cnt <= '0;
    end else if (shift) begin
      sr  <= shifted;
      cnt <= cnt + CW'(1);
    end
  end

  assign sout    = sr[0];
  assign shifted = {sin, sr[W-1:1]};
  assign last    = (cnt == len - CW'(1));

endmodule

// File: rtl/master_addr_tx.sv
// Master-side serial request engine: arbitrates, shifts device address, mode,
// memory address and write data, then collects read data or waits for ack drop.
//
// state      | meaning
// IDLE       | ready for a local request
// ARB        | bus_req held, waiting for bus_grant
// DEV_ADDR   | shifting device address bits
// WAIT_ACK   | waiting for decoder ack, timeout down-counter running
// MODE       | one cycle of read/write mode bit
// MEM_ADDR   | shifting memory address bits
// WDATA      | shifting write data bits
// WR_WAIT    | waiting for ack to fall to finish a write
// RD         | collecting serial read bits on rvalid
// SPLIT_WAIT | bus released after split, waiting for split_grant
module master_addr_tx
  import bus_pkg::*;
#(
  parameter int DEVICE_ADDR_WIDTH = DEF_DEVICE_ADDR_WIDTH,
  parameter int MEM_ADDR_WIDTH    = DEF_MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH        = DEF_DATA_WIDTH,
  parameter int ACK_TIMEOUT       = DEF_ACK_TIMEOUT
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         req,
  input  logic                         req_write,
  input  logic [DEVICE_ADDR_WIDTH-1:0] req_dev_addr,
  input  logic [MEM_ADDR_WIDTH-1:0]    req_mem_addr,
  input  logic [DATA_WIDTH-1:0]        req_wdata,
  output logic                         req_ready,
  output logic                         bus_req,
  input  logic                         bus_grant,
  output logic                         addr_valid,
  output logic                         addr_data,
  input  logic                         ack,
  input  logic                         split,
  input  logic                         split_grant,
  input  logic                         rvalid,
  input  logic                         rdata,
  output logic                         done,
  output logic                         err,
  output logic [DATA_WIDTH-1:0]        rdata_out
);

  localparam int TX_W  = max3(DEVICE_ADDR_WIDTH, MEM_ADDR_WIDTH, DATA_WIDTH);
  localparam int TX_CW = $clog2(TX_W + 1);
  localparam int RX_CW = $clog2(DATA_WIDTH + 1);
  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

  state_t state, state_nxt;

  logic                         lat_write;
  logic [DEVICE_ADDR_WIDTH-1:0] lat_dev;
  logic [MEM_ADDR_WIDTH-1:0]    lat_mem;
  logic [DATA_WIDTH-1:0]        lat_wdata;
  logic [TMO_W-1:0]             tmo_cnt;

  logic              tx_load, tx_shift, tx_sout, tx_last;
  logic [TX_W-1:0]   tx_load_data;
  logic [TX_CW-1:0]  tx_len;
  logic [TX_W-1:0]   unused_tx_shifted;
  logic [TX_CW-1:0]  unused_tx_cnt;

  logic                  rx_load, rx_shift, rx_last;
  logic [DATA_WIDTH-1:0] rx_shifted;
  logic [RX_CW-1:0]      rx_cnt;
  logic                  unused_rx_sout;

  logic latch_req, tmo_load, tmo_dec, bus_req_nxt, done_set, err_set, rdata_load;

  serial_shifter #(.W(TX_W), .CW(TX_CW)) u_tx (
    .clk       (clk),
    .rstn      (rstn),
    .load      (tx_load),
    .load_data (tx_load_data),
    .len       (tx_len),
    .shift     (tx_shift),
    .sin       (1'b0),
    .sout      (tx_sout),
    .shifted   (unused_tx_shifted),
    .cnt       (unused_tx_cnt),
    .last      (tx_last)
  );

  serial_shifter #(.W(DATA_WIDTH), .CW(RX_CW)) u_rx (
    .clk       (clk),
    .rstn      (rstn),
    .load      (rx_load),
    .load_data ('0),
    .len       (RX_CW'(DATA_WIDTH)),
    .shift     (rx_shift),
    .sin       (rdata),
    .sout      (unused_rx_sout),
    .shifted   (rx_shifted),
    .cnt       (rx_cnt),
    .last      (rx_last)
  );

  // the pulse cycle already sits in IDLE but must not look ready yet
  assign req_ready = (state == ST_IDLE) && !done && !err;

  always_ff @(posedge clk) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    latch_req    = 1'b0;
    tx_load      = 1'b0;
    tx_load_data = '0;
    tx_len       = TX_CW'(DEVICE_ADDR_WIDTH);
    tx_shift     = 1'b0;
    rx_load      = 1'b0;
    rx_shift     = 1'b0;
    tmo_load     = 1'b0;
    tmo_dec      = 1'b0;
    bus_req_nxt  = bus_req;
    done_set     = 1'b0;
    err_set      = 1'b0;
    rdata_load   = 1'b0;
    addr_valid   = 1'b0;
    addr_data    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req && req_ready) begin
          latch_req   = 1'b1;
          bus_req_nxt = 1'b1;
          state_nxt   = ST_ARB;
        end
      end
      ST_ARB: begin
        if (bus_grant) begin
          tx_load      = 1'b1;
          tx_load_data = TX_W'(lat_dev);
          state_nxt    = ST_DEV_ADDR;
        end
      end
      ST_DEV_ADDR: begin
        addr_valid = 1'b1;
        addr_data  = tx_sout;
        tx_shift   = 1'b1;
        tx_len     = TX_CW'(DEVICE_ADDR_WIDTH);
        if (tx_last) begin
          tmo_load  = 1'b1;
          state_nxt = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (ack) begin
          state_nxt = ST_MODE;
        end else if (tmo_cnt == '0) begin
          err_set     = 1'b1;
          bus_req_nxt = 1'b0;
          state_nxt   = ST_IDLE;
        end else begin
          tmo_dec = 1'b1;
        end
      end
      ST_MODE: begin
        addr_valid   = 1'b1;
        addr_data    = lat_write ? MODE_WRITE : MODE_READ;
        tx_load      = 1'b1;
        tx_load_data = TX_W'(lat_mem);
        state_nxt    = ST_MEM_ADDR;
      end
      ST_MEM_ADDR: begin
        addr_valid = 1'b1;
        addr_data  = tx_sout;
        tx_shift   = 1'b1;
        tx_len     = TX_CW'(MEM_ADDR_WIDTH);
        if (tx_last) begin
          if (lat_write == MODE_WRITE) begin
            tx_load      = 1'b1;
            tx_load_data = TX_W'(lat_wdata);
            state_nxt    = ST_WDATA;
          end else begin
            rx_load   = 1'b1;
            state_nxt = ST_RD;
          end
        end
      end
      ST_WDATA: begin
        addr_valid = 1'b1;
        addr_data  = tx_sout;
        tx_shift   = 1'b1;
        tx_len     = TX_CW'(DATA_WIDTH);
        if (tx_last) state_nxt = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        if (!ack) begin
          done_set    = 1'b1;
          bus_req_nxt = 1'b0;
          state_nxt   = ST_IDLE;
        end
      end
      ST_RD: begin
        // a split is only honoured before any read bit has arrived
        if (split && rx_cnt == '0) begin
          rx_load     = 1'b1;
          bus_req_nxt = 1'b0;
          state_nxt   = ST_SPLIT_WAIT;
        end else if (rvalid) begin
          rx_shift = 1'b1;
          if (rx_last) begin
            rdata_load  = 1'b1;
            done_set    = 1'b1;
            bus_req_nxt = 1'b0;
            state_nxt   = ST_IDLE;
          end
        end
      end
      ST_SPLIT_WAIT: begin
        if (split_grant) begin
          bus_req_nxt = 1'b1;
          state_nxt   = ST_RD;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      lat_write <= 1'b0;
      lat_dev   <= '0;
      lat_mem   <= '0;
      lat_wdata <= '0;
      tmo_cnt   <= '0;
      bus_req   <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rdata_out <= '0;
    end else begin
      if (latch_req) begin
        lat_write <= req_write;
        lat_dev   <= req_dev_addr;
        lat_mem   <= req_mem_addr;
        lat_wdata <= req_wdata;
      end
      if (tmo_load)     tmo_cnt <= TMO_W'(ACK_TIMEOUT);
      else if (tmo_dec) tmo_cnt <= tmo_cnt - TMO_W'(1);
      bus_req <= bus_req_nxt;
      done    <= done_set;
      err     <= err_set;
      if (rdata_load) rdata_out <= rx_shifted;
    end
  end

endmodule

// File: doc/master_addr_tx.md
# master_addr_tx

Master-side serial request engine that sits directly upstream of the bus address decoder. It accepts one parallel transaction from a local master, arbitrates for the bus and shifts the device address serially on `addr_valid`/`addr_data`. After the decoder acknowledges, it shifts a mode bit, the memory address and any write data. It then collects serial read data or waits for completion, including the split/split-grant resume path.

## Interface
- `DEVICE_ADDR_WIDTH`, 4: device-select bits, sent first, LSB first.
- `MEM_ADDR_WIDTH`, 12: in-slave address bits, LSB first.
- `DATA_WIDTH`, 8: data bits, LSB first.
- `ACK_TIMEOUT`, 15: cycles to wait for `ack` before abort.
- `clk  in  1  clock`
- `rstn  in  1  reset, synchronous, active-low`
- `req  in  1  local transaction request (sampled in IDLE)`
- `req_write  in  1  1=write, 0=read`
- `req_dev_addr  in  DEVICE_ADDR_WIDTH  target device`
- `req_mem_addr  in  MEM_ADDR_WIDTH  target address`
- `req_wdata  in  DATA_WIDTH  write data`
- `req_ready  out  1  high in IDLE only`
- `bus_req  out  1  request to arbiter`
- `bus_grant  in  1  arbiter grant`
- `addr_valid  out  1  serial-bit qualifier to decoder`
- `addr_data  out  1  serial bit to decoder`
- `ack  in  1  decoder ack (level, drops when decoder returns idle)`
- `split  in  1  slave split notice`
- `split_grant  in  1  bus split-resume grant`
- `rvalid  in  1  serial read-bit qualifier`
- `rdata  in  1  serial read bit`
- `done  out  1  one-cycle completion pulse`
- `err  out  1  one-cycle abort pulse (ack timeout)`
- `rdata_out  out  DATA_WIDTH  assembled read data, valid with `done` on reads`

## Operation
- Reset values: `req_ready`=1 (state IDLE), `bus_req`=0, `addr_valid`=0, `addr_data`=0, `done`=0, `err`=0, `rdata_out`=0. All counters and the latched request are cleared.
- IDLE: when `req`=1, latch all `req_*` fields, set `bus_req`=1 and go to ARB.
- ARB: hold `bus_req`. When `bus_grant`=1, go to DEV_ADDR with bit counter 0.
- DEV_ADDR: drive `addr_valid`=1 and `addr_data`=dev_addr[cnt] for exactly DEVICE_ADDR_WIDTH cycles, then go to WAIT_ACK.
- WAIT_ACK: `addr_valid`=0.
  - `ack`=1: go to MODE.
  - Timeout counter reaches ACK_TIMEOUT: pulse `err`, drop `bus_req`, go to IDLE.
- MODE: one cycle, `addr_valid`=1, `addr_data`=req_write. Go to MEM_ADDR.
- MEM_ADDR: MEM_ADDR_WIDTH cycles, LSB first.
  - Write: go to WDATA.
  - Read: go to RD.
- WDATA: DATA_WIDTH cycles, LSB first, then go to WR_WAIT.
- WR_WAIT: `addr_valid`=0. When `ack` falls to 0, pulse `done`, drop `bus_req`, go to IDLE.
- RD: `addr_valid`=0. Each cycle with `rvalid`=1 shifts `rdata` into bit position cnt. After DATA_WIDTH bits, load `rdata_out`, pulse `done`, drop `bus_req`, go to IDLE.
- Split (reads only): `split`=1 while in RD with zero bits received means go to SPLIT_WAIT.
  - SPLIT_WAIT: drop `bus_req` and the bit count. On `split_grant`=1, go to RD.
  - `split` is ignored in all other states.
- `req` outside IDLE is ignored; a new transaction is latched only from IDLE.
- `bus_grant` falling mid-transfer has no effect; the grant is sampled only in ARB.

## Timing
- Grant seen in cycle N: first device bit is driven in N+1. The last device bit is in N+DEVICE_ADDR_WIDTH.
- An `ack` sampled high in the first WAIT_ACK cycle gives MODE in the next cycle. Minimum header is DEVICE_ADDR_WIDTH+1+1+MEM_ADDR_WIDTH cycles.
- The timeout counter starts at 0 on WAIT_ACK entry. `err` fires on the cycle the count equals ACK_TIMEOUT, so there are ACK_TIMEOUT+1 WAIT_ACK cycles in total.
- `done` and `err` are registered single-cycle pulses. `req_ready` returns high in the cycle after the pulse.
- `rvalid` gaps are allowed and bits are counted only on `rvalid`=1.
- Reset asserted in any state returns to IDLE on the next edge, with all outputs at reset values and no `done`/`err` pulse.

## Structure
- Shared package `bus_pkg`:
  - State encoding: IDLE, ARB, DEV_ADDR, WAIT_ACK, MODE, MEM_ADDR, WDATA, WR_WAIT, RD, SPLIT_WAIT.
  - Mode-bit constants: `MODE_WRITE`=1, `MODE_READ`=0.
  - Default widths, so the decoder and this block agree.
- One sub-module `serial_shifter`: a parameterised LSB-first parallel-to-serial counter plus a serial-to-parallel counter. It is instantiated once for TX (dev/mem/wdata loaded per phase) and once for RX.

## Test plan
- Write dev=2, addr=0x0A5, data=0x3C; grant after 2 cycles, ack 2 cycles after dev bits -> `addr_data` sequence 0,1,0,0 | 1 | 12-bit 0x0A5 LSB-first | 0x3C LSB-first. `done` fires one cycle after `ack` falls.
- Read dev=1, addr=0x010; slave returns 0xA5 with one `rvalid` gap -> `rdata_out`=0xA5 with `done`, and `bus_req`=0 the next cycle.
- No `ack` -> `err` pulse after 16 WAIT_ACK cycles, `addr_valid` never reasserted, back to IDLE.
- Read with `split` in the first RD cycle, `split_grant` 20 cycles later, then 8 `rvalid` bits of 0x5A -> `bus_req` low during SPLIT_WAIT, `rdata_out`=0x5A.
- `rstn` low in the middle of MEM_ADDR -> all outputs at reset values next cycle. A new request then completes normally.
- `req` toggled during an active transaction -> ignored; only the latched transaction completes.
